fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
// Owns the write port (port B) of the 12-bit RGB frame buffer BRAM. Shares it between two
// requesters, the 3D block renderer pixel stream and the HUD overlay (score/health/combo),
// and sequences a per-frame clear sweep. Emits one registered write per cycle at most;
// the read/scan-out port is untouched.
// PARAMETERS
// WIDTH        512     frame buffer width in pixels; power of two
// HEIGHT       384     frame buffer height in pixels
// CLEAR_COLOR  12'h000 pixel value written by the clear sweep
// ADDR_W       $clog2(WIDTH*HEIGHT)  address width (derived, not overridden)
// PORTS
// clk_in            in   1       system clock
// rst_in            in   1       asynchronous reset, active-low
// frame_start_in    in   1       one-cycle pulse at start of a new render frame
// clear_en_in       in   1       1: run the clear sweep on frame_start_in
// rend_valid_in     in   1       renderer pixel valid
// rend_x_in         in   11      renderer pixel x
// rend_y_in         in   10      renderer pixel y
// rend_pixel_in     in   12      renderer {r,g,b} 4:4:4
// rend_ready_out    out  1       renderer beat accepted this cycle when valid&ready
// hud_valid_in      in   1       HUD pixel valid
// hud_x_in          in   11      HUD pixel x
// hud_y_in          in   10      HUD pixel y
// hud_pixel_in      in   12      HUD {r,g,b}
// hud_ready_out     out  1       HUD beat accepted when valid&ready
// fb_addr_out       out  ADDR_W  BRAM port B address
// fb_pixel_out      out  12      BRAM port B write data
// fb_we_out         out  1       BRAM port B write enable
// busy_out          out  1       1 while clear sweep in progress
// overrun_out       out  1       sticky: frame_start_in arrived during clear sweep
// drop_count_out    out  16      accepted out-of-range beats, saturating at 16'hFFFF
// BEHAVIOUR
// - Reset (rst_in=0, async): state IDLE; fb_we_out=0, fb_addr_out=0, fb_pixel_out=0,
//   busy_out=0, overrun_out=0, drop_count_out=0, clear counter=0, rr pointer=RENDERER.
// - FSM IDLE/CLEAR/RUN. IDLE: both readies 0. frame_start_in -> CLEAR if clear_en_in else RUN.
// - CLEAR: readies 0, busy_out=1; counter 0..WIDTH*HEIGHT-1, one write of CLEAR_COLOR per
//   cycle, fb_addr_out=counter registered. Write of last address -> RUN next cycle, counter=0.
//   frame_start_in during CLEAR ignored for sequencing, sets overrun_out (cleared only by reset).
// - RUN: frame_start_in & clear_en_in -> CLEAR (same cycle beats still accepted per rr rule);
//   frame_start_in & !clear_en_in -> stay RUN.
// - Arbitration in RUN: two-way round-robin. Only one valid -> it gets ready. Both valid ->
//   the one not granted last time wins; pointer updates only on an accepted beat.
//   Readies never depend on the requester's own valid; loser's ready=0.
// - Accepted beat at cycle N -> cycle N+1: fb_we_out=1, fb_addr_out=x+(y<<log2(WIDTH)),
//   fb_pixel_out=pixel. No beat accepted -> fb_we_out=0, addr/data hold last value.
// - Out-of-range (x>=WIDTH or y>=HEIGHT): beat still accepted (ready as normal), no write
//   (fb_we_out=0 at N+1), drop_count_out +1 at N+1 unless already 16'hFFFF.
// - Address arithmetic done at ADDR_W bits after range check; no wrap is ever written.
// - Reset asserted mid-sweep or mid-beat: pending write discarded, IDLE on release.
// STRUCTURE
// - fb_pkg: fb_state_t enum {IDLE,CLEAR,RUN}, FB_WIDTH/FB_HEIGHT defaults, pixel_t (12-bit),
//   requester_t enum {RENDERER,HUD}.
// - One sub-module: rr_arbiter2 (2 requests, accept strobe, grant vector, pointer flop).
// - Clear counter, FSM, output registers and drop counter live in the top.
// TESTING (run with WIDTH=4, HEIGHT=2 unless noted)
// - Reset release, frame_start_in with clear_en_in=1 -> 8 writes addr 0..7 data CLEAR_COLOR
//   on consecutive cycles, busy_out=1 throughout, readies 0, then RUN.
// - RUN, rend only: x=3,y=1,pixel=12'hF0A -> next cycle fb_we_out=1, addr=7, data=12'hF0A.
// - Both valid every cycle, 6 cycles -> grants alternate R,H,R,H,R,H; no beat lost.
// - rend x=4,y=0 accepted -> fb_we_out=0 next cycle, drop_count_out 0->1; preload to 16'hFFFF
//   and drop again -> stays 16'hFFFF.
// - frame_start_in at clear count 3 -> sweep continues to addr 7, overrun_out=1 until reset.
// - rst_in low at clear count 5 -> outputs zero immediately; on release state IDLE, readies 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame buffer write-port arbiter.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 512;
    localparam int unsigned FB_HEIGHT = 384;
    localparam int unsigned PIXEL_W   = 12;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {IDLE, CLEAR, RUN} fb_state_t;

    typedef enum logic {RENDERER, HUD} requester_t;

    function automatic requester_t rr_other(input requester_t r);
        return (r == RENDERER) ? HUD : RENDERER;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2
    import fb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    input  logic [1:0] accept_i,
    output logic [1:0] gnt_o
);

    requester_t ptr_q;

    // A grant looks only at the other requester, never at its own request.
    assign gnt_o[0] = en_i && (!req_i[1] || (ptr_q == RENDERER));
    assign gnt_o[1] = en_i && (!req_i[0] || (ptr_q == HUD));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= RENDERER;
        end else if (accept_i[0]) begin
            ptr_q <= rr_other(RENDERER);
        end else if (accept_i[1]) begin
            ptr_q <= rr_other(HUD);
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame buffer port B owner: clear sweep, renderer/HUD round-robin, registered write.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned WIDTH       = FB_WIDTH,
    parameter int unsigned HEIGHT      = FB_HEIGHT,
    parameter pixel_t      CLEAR_COLOR = 12'h000,
    localparam int unsigned ADDR_W     = $clog2(WIDTH * HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              frame_start_in,
    input  logic              clear_en_in,
    input  logic              rend_valid_in,
    input  logic [10:0]       rend_x_in,
    input  logic [9:0]        rend_y_in,
    input  logic [11:0]       rend_pixel_in,
    output logic              rend_ready_out,
    input  logic              hud_valid_in,
    input  logic [10:0]       hud_x_in,
    input  logic [9:0]        hud_y_in,
    input  logic [11:0]       hud_pixel_in,
    output logic              hud_ready_out,
    output logic [ADDR_W-1:0] fb_addr_out,
    output logic [11:0]       fb_pixel_out,
    output logic              fb_we_out,
    output logic              busy_out,
    output logic              overrun_out,
    output logic [15:0]       drop_count_out
);

    localparam int unsigned LOG2W = $clog2(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    fb_state_t         state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    pixel_t            fb_pixel_q;
    logic              busy_q;
    logic              overrun_q;
    logic [15:0]       drop_q;

    logic [1:0]        gnt;
    logic [1:0]        accept;
    logic              beat_acc;
    logic [10:0]       sel_x;
    logic [9:0]        sel_y;
    pixel_t            sel_pixel;
    logic              in_range;
    logic [ADDR_W-1:0] beat_addr;

    rr_arbiter2 u_rr (
        .clk_i    (clk_in),
        .rst_ni   (rst_in),
        .en_i     (state_q == RUN),
        .req_i    ({hud_valid_in, rend_valid_in}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign rend_ready_out = gnt[0];
    assign hud_ready_out  = gnt[1];
    assign accept         = {hud_valid_in, rend_valid_in} & gnt;
    assign beat_acc       = |accept;

    assign sel_x     = accept[1] ? hud_x_in     : rend_x_in;
    assign sel_y     = accept[1] ? hud_y_in     : rend_y_in;
    assign sel_pixel = accept[1] ? hud_pixel_in : rend_pixel_in;

    // Range check at full input width so an out-of-range beat never aliases into the buffer.
    assign in_range  = (32'(sel_x) < WIDTH) && (32'(sel_y) < HEIGHT);
    assign beat_addr = ADDR_W'(sel_x) + (ADDR_W'(sel_y) << LOG2W);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            clr_cnt_q  <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_pixel_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            drop_q     <= '0;
        end else begin
            fb_we_q <= 1'b0;
            // Tracks the sweep writes, which appear one cycle after the CLEAR state issues them.
            busy_q  <= (state_q == CLEAR);
            unique case (state_q)
                IDLE: begin
                    if (frame_start_in) begin
                        state_q <= clear_en_in ? CLEAR : RUN;
                    end
                end
                CLEAR: begin
                    fb_we_q    <= 1'b1;
                    fb_addr_q  <= clr_cnt_q;
                    fb_pixel_q <= CLEAR_COLOR;
                    if (frame_start_in) begin
                        overrun_q <= 1'b1;
                    end
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_cnt_q <= '0;
                        state_q   <= RUN;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                RUN: begin
                    if (beat_acc) begin
                        if (in_range) begin
                            fb_we_q    <= 1'b1;
                            fb_addr_q  <= beat_addr;
                            fb_pixel_q <= sel_pixel;
                        end else if (drop_q != 16'hFFFF) begin
                            drop_q <= drop_q + 16'd1;
                        end
                    end
                    if (frame_start_in && clear_en_in) begin
                        state_q <= CLEAR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb_we_out      = fb_we_q;
    assign fb_addr_out    = fb_addr_q;
    assign fb_pixel_out   = fb_pixel_q;
    assign busy_out       = busy_q;
    assign overrun_out    = overrun_q;
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scoreboard bench for fb_write_arbiter on a 4x2 buffer.
module tb_fb_write_arbiter;
    import fb_pkg::*;

    typedef struct packed {
        logic [2:0]  addr;
        logic [11:0] pix;
    } wr_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        frame_start_in;
    logic        clear_en_in;
    logic        rend_valid_in;
    logic [10:0] rend_x_in;
    logic [9:0]  rend_y_in;
    logic [11:0] rend_pixel_in;
    logic        rend_ready_out;
    logic        hud_valid_in;
    logic [10:0] hud_x_in;
    logic [9:0]  hud_y_in;
    logic [11:0] hud_pixel_in;
    logic        hud_ready_out;
    logic [2:0]  fb_addr_out;
    logic [11:0] fb_pixel_out;
    logic        fb_we_out;
    logic        busy_out;
    logic        overrun_out;
    logic [15:0] drop_count_out;

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         vectors = 0;
    int         miscompares = 0;
    requester_t model_ptr;

    fb_write_arbiter #(
        .WIDTH  (4),
        .HEIGHT (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .frame_start_in (frame_start_in),
        .clear_en_in    (clear_en_in),
        .rend_valid_in  (rend_valid_in),
        .rend_x_in      (rend_x_in),
        .rend_y_in      (rend_y_in),
        .rend_pixel_in  (rend_pixel_in),
        .rend_ready_out (rend_ready_out),
        .hud_valid_in   (hud_valid_in),
        .hud_x_in       (hud_x_in),
        .hud_y_in       (hud_y_in),
        .hud_pixel_in   (hud_pixel_in),
        .hud_ready_out  (hud_ready_out),
        .fb_addr_out    (fb_addr_out),
        .fb_pixel_out   (fb_pixel_out),
        .fb_we_out      (fb_we_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out),
        .drop_count_out (drop_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Every write the DUT makes must match the oldest expected write.
    always @(negedge clk_in) begin
        if (fb_we_out === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got addr=%0d pix=%h, required no write",
                         fb_addr_out, fb_pixel_out);
            end else begin
                mon_e = exp_q.pop_front();
                if ({fb_addr_out, fb_pixel_out} !== mon_e) begin
                    miscompares++;
                    $display("FAIL write_data: got addr=%0d pix=%h, required addr=%0d pix=%h",
                             fb_addr_out, fb_pixel_out, mon_e.addr, mon_e.pix);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        frame_start_in = 1'b0; clear_en_in = 1'b0;
        rend_valid_in = 1'b0; rend_x_in = '0; rend_y_in = '0; rend_pixel_in = '0;
        hud_valid_in = 1'b0; hud_x_in = '0; hud_y_in = '0; hud_pixel_in = '0;
        model_ptr = RENDERER;
        step(); step();
        @(negedge clk_in);
        vectors++;
        if ({fb_we_out, fb_addr_out, fb_pixel_out, busy_out, overrun_out, drop_count_out,
             rend_ready_out, hud_ready_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%b addr=%0d pix=%h busy=%b ovr=%b drop=%0d rr=%b hr=%b, required all 0",
                     fb_we_out, fb_addr_out, fb_pixel_out, busy_out, overrun_out,
                     drop_count_out, rend_ready_out, hud_ready_out);
        end
        step();
        rst_in = 1'b1;
        rend_valid_in = 1'b1; hud_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            vectors++;
            if ({rend_ready_out, hud_ready_out} !== 2'b00) begin
                miscompares++;
                $display("FAIL idle_readies: got %b%b, required 00", rend_ready_out, hud_ready_out);
            end
        end
        step();
        rend_valid_in = 1'b0; hud_valid_in = 1'b0;
    endtask

    task automatic test_clear_sweep();
        step();
        frame_start_in = 1'b1; clear_en_in = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back('{addr: 3'(k), pix: 12'h000});
        step();
        frame_start_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            vectors++;
            if ({rend_ready_out, hud_ready_out} !== 2'b00) begin
                miscompares++;
                $display("FAIL clear_readies[%0d]: got %b%b, required 00", k,
                         rend_ready_out, hud_ready_out);
            end
            if (k > 0) begin
                vectors++;
                if ({busy_out, fb_we_out} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL clear_busy_we[%0d]: got busy=%b we=%b, required 1 1", k,
                             busy_out, fb_we_out);
                end
            end
        end
        @(negedge clk_in);
        vectors++;
        if ({busy_out, fb_we_out} !== 2'b11) begin
            miscompares++;
            $display("FAIL clear_last_write: got busy=%b we=%b, required 1 1", busy_out, fb_we_out);
        end
        @(negedge clk_in);
        vectors++;
        if ({busy_out, rend_ready_out, hud_ready_out} !== 3'b011) begin
            miscompares++;
            $display("FAIL clear_to_run: got busy=%b rr=%b hr=%b, required 0 1 1",
                     busy_out, rend_ready_out, hud_ready_out);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL clear_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_single_beat();
        step();
        rend_valid_in = 1'b1; rend_x_in = 11'd3; rend_y_in = 10'd1; rend_pixel_in = 12'hF0A;
        exp_q.push_back('{addr: 3'd7, pix: 12'hF0A});
        @(negedge clk_in);
        vectors++;
        if (rend_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL single_rend_ready: got %b, required 1", rend_ready_out);
        end
        model_ptr = HUD;
        step();
        rend_valid_in = 1'b0;
        hud_valid_in = 1'b1; hud_x_in = 11'd2; hud_y_in = 10'd0; hud_pixel_in = 12'h5C3;
        exp_q.push_back('{addr: 3'd2, pix: 12'h5C3});
        @(negedge clk_in);
        vectors++;
        if (fb_we_out !== 1'b1) begin
            miscompares++;
            $display("FAIL single_rend_we: got %b, required 1", fb_we_out);
        end
        vectors++;
        if (hud_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL single_hud_ready: got %b, required 1", hud_ready_out);
        end
        model_ptr = RENDERER;
        step();
        hud_valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] rx [4] = '{11'd0, 11'd1, 11'd2, 11'd3};
        logic [9:0]  ry [4] = '{10'd0, 10'd0, 10'd1, 10'd1};
        logic [11:0] rp [4] = '{12'h111, 12'h222, 12'h333, 12'h444};
        logic [10:0] hx [4] = '{11'd3, 11'd0, 11'd1, 11'd2};
        logic [9:0]  hy [4] = '{10'd0, 10'd1, 10'd1, 10'd0};
        logic [11:0] hp [4] = '{12'hA11, 12'hA22, 12'hA33, 12'hA44};
        int ri = 0;
        int hi = 0;
        logic exp_r;
        for (int c = 0; c < 6; c++) begin
            step();
            rend_valid_in = 1'b1; rend_x_in = rx[ri]; rend_y_in = ry[ri]; rend_pixel_in = rp[ri];
            hud_valid_in = 1'b1; hud_x_in = hx[hi]; hud_y_in = hy[hi]; hud_pixel_in = hp[hi];
            @(negedge clk_in);
            exp_r = (model_ptr == RENDERER);
            vectors++;
            if ({rend_ready_out, hud_ready_out} !== {exp_r, !exp_r}) begin
                miscompares++;
                $display("FAIL b2b_grant[%0d]: got rr=%b hr=%b, required rr=%b hr=%b", c,
                         rend_ready_out, hud_ready_out, exp_r, !exp_r);
            end
            if (exp_r) begin
                exp_q.push_back('{addr: 3'(rx[ri] + (11'(ry[ri]) << 2)), pix: rp[ri]});
                ri++;
                model_ptr = HUD;
            end else begin
                exp_q.push_back('{addr: 3'(hx[hi] + (11'(hy[hi]) << 2)), pix: hp[hi]});
                hi++;
                model_ptr = RENDERER;
            end
        end
        step();
        rend_valid_in = 1'b0; hud_valid_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        vectors++;
        if (exp_q.size() != 0 || ri != 3 || hi != 3) begin
            miscompares++;
            $display("FAIL b2b_drained: got pending=%0d r=%0d h=%0d, required 0 3 3",
                     exp_q.size(), ri, hi);
        end
    endtask

    task automatic test_out_of_range();
        step();
        rend_valid_in = 1'b1; rend_x_in = 11'd4; rend_y_in = 10'd0; rend_pixel_in = 12'hFFF;
        @(negedge clk_in);
        vectors++;
        if (rend_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_ready: got %b, required 1", rend_ready_out);
        end
        step();
        rend_valid_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (drop_count_out !== 16'd1) begin
            miscompares++;
            $display("FAIL oor_drop1: got %0d, required 1", drop_count_out);
        end
        hud_valid_in = 1'b1; hud_x_in = 11'd0; hud_y_in = 10'd2; hud_pixel_in = 12'h0F0;
        step();
        hud_valid_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (drop_count_out !== 16'd2) begin
            miscompares++;
            $display("FAIL oor_drop2: got %0d, required 2", drop_count_out);
        end
        step();
        rend_valid_in = 1'b1; rend_x_in = 11'h7FF; rend_y_in = 10'd0;
        repeat (65533) @(posedge clk_in);
        #1;
        rend_valid_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (drop_count_out !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL oor_drop_full: got %h, required ffff", drop_count_out);
        end
        step();
        rend_valid_in = 1'b1; rend_x_in = 11'd1; rend_y_in = 10'd5;
        step();
        rend_valid_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (drop_count_out !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL oor_drop_sat: got %h, required ffff", drop_count_out);
        end
        model_ptr = HUD;
    endtask

    task automatic test_overrun();
        step();
        frame_start_in = 1'b1; clear_en_in = 1'b1;
        rend_valid_in = 1'b1; rend_x_in = 11'd1; rend_y_in = 10'd0; rend_pixel_in = 12'hABC;
        exp_q.push_back('{addr: 3'd1, pix: 12'hABC});
        for (int k = 0; k < 8; k++) exp_q.push_back('{addr: 3'(k), pix: 12'h000});
        @(negedge clk_in);
        vectors++;
        if (rend_ready_out !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_same_cycle_ready: got %b, required 1", rend_ready_out);
        end
        model_ptr = HUD;
        step();
        frame_start_in = 1'b0; rend_valid_in = 1'b0;
        repeat (3) step();
        frame_start_in = 1'b1;
        @(negedge clk_in);
        vectors++;
        if (overrun_out !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_before: got %b, required 0", overrun_out);
        end
        step();
        frame_start_in = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (overrun_out !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set: got %b, required 1", overrun_out);
        end
        repeat (8) @(negedge clk_in);
        vectors++;
        if ({overrun_out, rend_ready_out, hud_ready_out} !== 3'b111 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ovr_after_sweep: got ovr=%b rr=%b hr=%b pending=%0d, required 1 1 1 0",
                     overrun_out, rend_ready_out, hud_ready_out, exp_q.size());
        end
        step();
        frame_start_in = 1'b1; clear_en_in = 1'b0;
        step();
        frame_start_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        vectors++;
        if ({overrun_out, busy_out, fb_we_out, rend_ready_out} !== 4'b1001) begin
            miscompares++;
            $display("FAIL ovr_sticky_run: got ovr=%b busy=%b we=%b rr=%b, required 1 0 0 1",
                     overrun_out, busy_out, fb_we_out, rend_ready_out);
        end
    endtask

    task automatic test_reset_mid_sweep();
        step();
        frame_start_in = 1'b1; clear_en_in = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back('{addr: 3'(k), pix: 12'h000});
        step();
        frame_start_in = 1'b0;
        repeat (5) step();
        rst_in = 1'b0;
        #1;
        vectors++;
        if ({fb_we_out, fb_addr_out, fb_pixel_out, busy_out, overrun_out, drop_count_out}
            !== '0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got we=%b addr=%0d pix=%h busy=%b ovr=%b drop=%h, required all 0",
                     fb_we_out, fb_addr_out, fb_pixel_out, busy_out, overrun_out, drop_count_out);
        end
        step(); step();
        rst_in = 1'b1;
        rend_valid_in = 1'b1; hud_valid_in = 1'b1;
        repeat (3) begin
            @(negedge clk_in);
            vectors++;
            if ({rend_ready_out, hud_ready_out, fb_we_out} !== 3'b000) begin
                miscompares++;
                $display("FAIL midreset_idle: got rr=%b hr=%b we=%b, required 0 0 0",
                         rend_ready_out, hud_ready_out, fb_we_out);
            end
        end
        rend_valid_in = 1'b0; hud_valid_in = 1'b0;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL midreset_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear_sweep();
        test_single_beat();
        test_back_to_back();
        test_out_of_range();
        test_overrun();
        test_reset_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
